// File: rtl/lenet_img_pkg.sv
// lenet_img_pkg: image geometry, pixel/image types and streamer states; IMAGE_PAD_EN selects the padded output frame
package lenet_img_pkg;
    localparam int IMG_H = 28;
    localparam int IMG_W = 28;
    localparam int PIX_W = 8;
    localparam int PAD   = 2;
`ifdef IMAGE_PAD_EN
    localparam int OUT_H = IMG_H + 2 * PAD;
    localparam int OUT_W = IMG_W + 2 * PAD;
`else
    localparam int OUT_H = IMG_H;
    localparam int OUT_W = IMG_W;
`endif
    localparam int ROW_W = $clog2(OUT_H);
    localparam int COL_W = $clog2(OUT_W);
    typedef logic signed [PIX_W-1:0] pixel_t;
    typedef pixel_t image_t [IMG_H][IMG_W];
    typedef enum logic {IDLE, STREAM} strm_state_e;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: row-major position over an HxW frame with a look-ahead of the next position
module raster_counter #(
    parameter int H = 28,
    parameter int W = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 adv,
    output logic [$clog2(H)-1:0] row,
    output logic [$clog2(W)-1:0] col,
    output logic [$clog2(H)-1:0] nxt_row,
    output logic [$clog2(W)-1:0] nxt_col,
    output logic                 last_col,
    output logic                 last_frame
);
    localparam int RW = $clog2(H);
    localparam int CW = $clog2(W);
    // next position: clear on start, wrap the column at row end, wrap the frame after the final beat
    always_comb begin
        last_col   = col == CW'(W - 1);
        last_frame = last_col && row == RW'(H - 1);
        nxt_col    = (clr || (adv && last_col)) ? '0 : adv ? col + 1'b1 : col;
        nxt_row    = (clr || (adv && last_frame)) ? '0 : (adv && last_col) ? row + 1'b1 : row;
    end
    // position registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else begin
            row <= nxt_row;
            col <= nxt_col;
        end
    end
endmodule

// File: rtl/image_pixel_streamer.sv
// image_pixel_streamer: streams a 28x28 image in raster order over valid/ready; IMAGE_PAD_EN adds a PAD-wide zero border
module image_pixel_streamer
    import lenet_img_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  image_t           image,
    output logic             busy,
    output logic             done,
    output logic             m_valid,
    input  logic             m_ready,
    output pixel_t           m_data,
    output logic             m_sof,
    output logic             m_eol,
    output logic             m_eof,
    output logic [ROW_W-1:0] m_row,
    output logic [COL_W-1:0] m_col
);
    strm_state_e      state, nxt_state;
    logic             clr, adv, fin, nxt_valid, last_col, last_frame;
    logic [ROW_W-1:0] nxt_row;
    logic [COL_W-1:0] nxt_col;
    pixel_t           pix;

    raster_counter #(.H(OUT_H), .W(OUT_W)) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .adv       (adv),
        .row       (m_row),
        .col       (m_col),
        .nxt_row   (nxt_row),
        .nxt_col   (nxt_col),
        .last_col  (last_col),
        .last_frame(last_frame)
    );

    // next state: start opens a frame from IDLE, the accepted final beat closes it
    always_comb begin
        clr       = state == IDLE && start;
        adv       = m_valid && m_ready;
        fin       = adv && last_col && last_frame;
        nxt_state = state == IDLE ? (start ? STREAM : IDLE) : (fin ? IDLE : STREAM);
        nxt_valid = nxt_state == STREAM;
    end

`ifdef IMAGE_PAD_EN
    logic [ROW_W-1:0] img_r;
    logic [COL_W-1:0] img_c;
    logic             inside;
    // pixel for the next beat: border beats are zero, interior beats read the shifted image
    always_comb begin
        img_r  = nxt_row - ROW_W'(PAD);
        img_c  = nxt_col - COL_W'(PAD);
        inside = nxt_row >= ROW_W'(PAD) && nxt_row < ROW_W'(PAD + IMG_H) &&
                 nxt_col >= COL_W'(PAD) && nxt_col < COL_W'(PAD + IMG_W);
        pix    = inside ? image[img_r][img_c] : '0;
    end
`else
    // pixel for the next beat read straight from the image
    always_comb pix = image[nxt_row][nxt_col];
`endif

    // registered outputs; during a stall the look-ahead equals the current beat so everything holds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
        end else begin
            state   <= nxt_state;
            busy    <= nxt_valid;
            done    <= fin;
            m_valid <= nxt_valid;
            m_data  <= nxt_valid ? pix : '0;
            m_sof   <= nxt_valid && nxt_row == '0 && nxt_col == '0;
            m_eol   <= nxt_valid && nxt_col == COL_W'(OUT_W - 1);
            m_eof   <= nxt_valid && nxt_col == COL_W'(OUT_W - 1) && nxt_row == ROW_W'(OUT_H - 1);
        end
    end
endmodule
